// File: rtl/diff_hs_pkg.sv
// diff_hs_pkg: FSM state codes shared by the diff core handshake master
package diff_hs_pkg;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_DONE = 3'd2;
    localparam logic [2:0] DRAIN     = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;
endpackage

// File: rtl/diff_hs_master_if.sv
// diff_hs_master_if: request, core (ap_ctrl_hs) and response signals of the diff core master
interface diff_hs_master_if #(parameter int DW = 32, parameter int CW = 16);
    logic          req_valid, req_ready;
    logic [DW-1:0] req_x, req_dx, req_u, req_a, req_y;
    logic          core_start, core_ready, core_done, core_idle;
    logic [DW-1:0] core_x, core_dx, core_u, core_a, core_y, core_ret;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [CW-1:0] rsp_cycles;
    logic          rsp_err, busy;
    modport master (
        input  req_valid, req_x, req_dx, req_u, req_a, req_y,
        input  core_ready, core_done, core_idle, core_ret, rsp_ready,
        output req_ready, core_start, core_x, core_dx, core_u, core_a, core_y,
        output rsp_valid, rsp_data, rsp_cycles, rsp_err, busy
    );
    modport slave (
        output req_valid, req_x, req_dx, req_u, req_a, req_y,
        output core_ready, core_done, core_idle, core_ret, rsp_ready,
        input  req_ready, core_start, core_x, core_dx, core_u, core_a, core_y,
        input  rsp_valid, rsp_data, rsp_cycles, rsp_err, busy
    );
endinterface

// File: rtl/diff_hs_timer.sv
// diff_hs_timer: per-job cycle counter with saturating report value and timeout detect
module diff_hs_timer #(parameter int CW = 16, parameter int TIMEOUT = 1024) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cycles,
    output logic          timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    assign timeout = tcnt == TW'(TIMEOUT);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cycles <= '0;
            tcnt   <= '0;
        end else if (en) begin
            cycles <= (&cycles) ? cycles : cycles + 1'b1;
            tcnt   <= timeout ? tcnt : tcnt + 1'b1;
        end
    end
endmodule

// File: rtl/diff_hs_master.sv
// diff_hs_master: ap_ctrl_hs initiator carrying one diff-core job from request to response
module diff_hs_master
    import diff_hs_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 16
) (
    input logic ap_clk,
    input logic ap_rst,
    diff_hs_master_if.master bus
);
    typedef struct packed { logic [DW-1:0] x, dx, u, a, y; } job_t;
    typedef struct packed { logic [DW-1:0] data; logic [CW-1:0] cycles; logic err; } rsp_t;
    logic [2:0]    state;
    job_t          job;
    rsp_t          rsp;
    logic [CW-1:0] cycles;
    logic          timeout;
    diff_hs_timer #(.CW(CW), .TIMEOUT(TIMEOUT)) u_timer (
        .clk(ap_clk), .rst(ap_rst), .clr(state == IDLE),
        .en(state == START || state == WAIT_DONE), .cycles(cycles), .timeout(timeout)
    );
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
            job   <= '0;
            rsp   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    job   <= {bus.req_x, bus.req_dx, bus.req_u, bus.req_a, bus.req_y};
                    state <= START;
                end
                START, WAIT_DONE:
                    if (bus.core_done && (bus.core_ready || state == WAIT_DONE)) begin
                        rsp   <= {bus.core_ret, cycles, 1'b0};
                        state <= RESP;
                    end else if (timeout) begin
                        rsp   <= {{DW{1'b0}}, cycles, 1'b1};
                        state <= DRAIN;
                    end else if (bus.core_ready) state <= WAIT_DONE;
                DRAIN: if (bus.core_idle) state <= RESP;
                RESP: if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.req_ready  = state == IDLE;
    assign bus.core_start = state == START;
    assign bus.rsp_valid  = state == RESP;
    assign bus.busy       = state != IDLE;
    assign {bus.core_x, bus.core_dx, bus.core_u, bus.core_a, bus.core_y} = job;
    assign {bus.rsp_data, bus.rsp_cycles, bus.rsp_err} = rsp;
endmodule

// File: tb/tb_diff_hs_master.sv
// tb_diff_hs_master: randomized jobs against a behavioural core model and expected-response rules
module tb_diff_hs_master;
    typedef struct packed { logic [31:0] x, dx, u, a, y; } job_t;
    logic clk = 0, rst = 1, sel = 0;
    logic req_valid = 0, core_ready = 0, core_done = 0, core_idle = 1, rsp_ready = 0;
    job_t req = '0;
    logic [31:0] core_ret = '0;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    diff_hs_master_if #(.DW(32), .CW(16)) ba ();
    diff_hs_master_if #(.DW(32), .CW(4)) bb ();
    diff_hs_master #(.DW(32), .TIMEOUT(16), .CW(16)) dut_a (.ap_clk(clk), .ap_rst(rst), .bus(ba.master));
    diff_hs_master #(.DW(32), .TIMEOUT(64), .CW(4)) dut_b (.ap_clk(clk), .ap_rst(rst), .bus(bb.master));
    assign {ba.req_x, ba.req_dx, ba.req_u, ba.req_a, ba.req_y} = req;
    assign {bb.req_x, bb.req_dx, bb.req_u, bb.req_a, bb.req_y} = req;
    assign ba.req_valid = req_valid && !sel;
    assign bb.req_valid = req_valid && sel;
    assign ba.core_ready = core_ready;
    assign bb.core_ready = core_ready;
    assign ba.core_done = core_done;
    assign bb.core_done = core_done;
    assign ba.core_idle = core_idle;
    assign bb.core_idle = core_idle;
    assign ba.core_ret = core_ret;
    assign bb.core_ret = core_ret;
    assign ba.rsp_ready = rsp_ready;
    assign bb.rsp_ready = rsp_ready;
    logic req_ready, core_start, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_data;
    logic [15:0] rsp_cycles;
    job_t core_ops;
    assign req_ready  = sel ? bb.req_ready : ba.req_ready;
    assign core_start = sel ? bb.core_start : ba.core_start;
    assign rsp_valid  = sel ? bb.rsp_valid : ba.rsp_valid;
    assign rsp_err    = sel ? bb.rsp_err : ba.rsp_err;
    assign busy       = sel ? bb.busy : ba.busy;
    assign rsp_data   = sel ? bb.rsp_data : ba.rsp_data;
    assign rsp_cycles = sel ? {12'b0, bb.rsp_cycles} : ba.rsp_cycles;
    assign core_ops   = sel ? {bb.core_x, bb.core_dx, bb.core_u, bb.core_a, bb.core_y}
                            : {ba.core_x, ba.core_dx, ba.core_u, ba.core_a, ba.core_y};

    function automatic job_t rand_job();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [15:0] exp_cycles(input int rd, input int dd, input int cw);
        int t, m;
        t = rd + dd;
        m = (1 << cw) - 1;
        return 16'(t > m ? m : t);
    endfunction

    // Core model: ready rd cycles after start rises, done dd cycles after that; a hung
    // core never finishes in time, then pulses a stale done and goes idle a bit later.
    task automatic run_job(input job_t j, input int rd, input int dd, input logic [31:0] ret,
                           input bit hang, input int rsp_wait, input bit hold_req,
                           output bit got, output logic [31:0] d, output logic [15:0] c,
                           output logic e, output int start_hi, output bit ops_ok,
                           output bit stable_ok, output bit rr_low);
        int k, n, to;
        to = sel ? 64 : 16;
        start_hi = 0; ops_ok = 1; stable_ok = 1; rr_low = 1;
        req_valid = 1; req = j; n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 0; req = rand_job(); k = 0;
        while (!rsp_valid && k < 200) begin
            start_hi += int'(core_start);
            if (core_start && core_ops !== j) ops_ok = 0;
            core_ready = k == rd;
            core_done  = hang ? k == to + 2 : k == rd + dd;
            core_ret   = core_done ? (hang ? $urandom() : ret) : $urandom();
            core_idle  = !hang || k >= to + 4;
            @(negedge clk);
            k++;
        end
        core_ready = 0; core_done = 0; core_idle = 1;
        got = rsp_valid; d = rsp_data; c = rsp_cycles; e = rsp_err;
        for (int i = 0; i < rsp_wait; i++) begin
            req_valid = hold_req;
            if (hold_req) req = rand_job();
            @(negedge clk);
            if ({rsp_valid, rsp_data, rsp_cycles, rsp_err} !== {1'b1, d, c, e}) stable_ok = 0;
            if (req_ready) rr_low = 0;
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset;
        sel = 0; rst = 1;
        repeat (3) @(negedge clk);
        n_chk++; if (req_ready !== 1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_chk++; if (core_start !== 0) begin n_fail++; $display("FAIL reset_core_start: got %b want 0", core_start); end
        n_chk++; if (rsp_valid !== 0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_chk++; if ({rsp_data, rsp_cycles, rsp_err} !== '0) begin n_fail++; $display("FAIL reset_rsp: got %h/%0d/%b want 0/0/0", rsp_data, rsp_cycles, rsp_err); end
        n_chk++; if (core_ops !== '0) begin n_fail++; $display("FAIL reset_ops: got %h want 0", core_ops); end
        n_chk++; if (busy !== 0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit got, ops_ok, st, rr; logic [31:0] d; logic [15:0] c; logic e; int sh;
        sel = 0;
        run_job({32'd1, 32'd2, 32'd3, 32'd4, 32'd5}, 0, 0, 32'hDEAD, 0, 0, 0, got, d, c, e, sh, ops_ok, st, rr);
        n_chk++; if (got !== 1) begin n_fail++; $display("FAIL basic_rsp_valid: got %b want 1", got); end
        n_chk++; if (d !== 32'hDEAD) begin n_fail++; $display("FAIL basic_data: got %h want dead", d); end
        n_chk++; if (e !== 0) begin n_fail++; $display("FAIL basic_err: got %b want 0", e); end
        n_chk++; if (sh !== 1) begin n_fail++; $display("FAIL basic_start_cycles: got %0d want 1", sh); end
        n_chk++; if (ops_ok !== 1) begin n_fail++; $display("FAIL basic_ops: got %b want 1", ops_ok); end
        n_chk++; if (c !== 16'd0) begin n_fail++; $display("FAIL basic_cycles: got %0d want 0", c); end
    endtask

    task automatic test_slow_core;
        bit got, ops_ok, st, rr; logic [31:0] d; logic [15:0] c; logic e; int sh;
        sel = 0;
        run_job(rand_job(), 2, 10, 32'h1234, 0, 0, 0, got, d, c, e, sh, ops_ok, st, rr);
        n_chk++; if (d !== 32'h1234 || got !== 1) begin n_fail++; $display("FAIL slow_data: got %h valid %b want 1234", d, got); end
        n_chk++; if (c !== 16'd12) begin n_fail++; $display("FAIL slow_cycles: got %0d want 12", c); end
        n_chk++; if (e !== 0) begin n_fail++; $display("FAIL slow_err: got %b want 0", e); end
        n_chk++; if (ops_ok !== 1 || sh !== 3) begin n_fail++; $display("FAIL slow_ops: stable %b start %0d want 1 3", ops_ok, sh); end
    endtask

    task automatic test_timeout;
        bit got, ops_ok, st, rr; logic [31:0] d; logic [15:0] c; logic e; int sh; logic [31:0] ret;
        sel = 0;
        run_job(rand_job(), 1, 0, 32'hBEEF, 1, 0, 0, got, d, c, e, sh, ops_ok, st, rr);
        n_chk++; if (got !== 1) begin n_fail++; $display("FAIL timeout_rsp_valid: got %b want 1", got); end
        n_chk++; if (e !== 1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", e); end
        n_chk++; if (d !== 0) begin n_fail++; $display("FAIL timeout_data: got %h want 0", d); end
        ret = $urandom();
        run_job(rand_job(), 1, 3, ret, 0, 0, 0, got, d, c, e, sh, ops_ok, st, rr);
        n_chk++; if ({got, d, c, e} !== {1'b1, ret, 16'd4, 1'b0}) begin n_fail++; $display("FAIL after_timeout: got %b %h %0d %b want 1 %h 4 0", got, d, c, e, ret); end
    endtask

    task automatic test_back_to_back;
        bit got, ops_ok, st, rr; logic [31:0] d, r1, r2; logic [15:0] c; logic e; int sh;
        sel = 0; r1 = $urandom(); r2 = $urandom();
        run_job(rand_job(), 1, 2, r1, 0, 20, 1, got, d, c, e, sh, ops_ok, st, rr);
        n_chk++; if (st !== 1) begin n_fail++; $display("FAIL hold_rsp_stable: got %b want 1", st); end
        n_chk++; if (rr !== 1) begin n_fail++; $display("FAIL hold_req_ready_low: got %b want 1", rr); end
        n_chk++; if (d !== r1) begin n_fail++; $display("FAIL hold_data: got %h want %h", d, r1); end
        run_job(rand_job(), 0, 1, r2, 0, 0, 0, got, d, c, e, sh, ops_ok, st, rr);
        n_chk++; if ({got, d, ops_ok} !== {1'b1, r2, 1'b1}) begin n_fail++; $display("FAIL second_job: got %b %h ops %b want 1 %h 1", got, d, ops_ok, r2); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        sel = 0;
        req_valid = 1; req = rand_job();
        @(negedge clk);
        req_valid = 0;
        n_chk++; if (core_start !== 1) begin n_fail++; $display("FAIL mid_start_high: got %b want 1", core_start); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        n_chk++; if ({core_start, busy, req_ready} !== 3'b001) begin n_fail++; $display("FAIL rst_in_start: start/busy/ready got %b want 001", {core_start, busy, req_ready}); end
        req_valid = 1; req = rand_job();
        @(negedge clk);
        req_valid = 0; core_ready = 1;
        @(negedge clk);
        core_ready = 0;
        n_chk++; if ({busy, core_start} !== 2'b10) begin n_fail++; $display("FAIL mid_wait_done: busy/start got %b want 10", {busy, core_start}); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        n_chk++; if ({core_start, rsp_valid, req_ready, busy} !== 4'b0010) begin n_fail++; $display("FAIL rst_in_wait: start/valid/ready/busy got %b want 0010", {core_start, rsp_valid, req_ready, busy}); end
        n_chk++; if (core_ops !== '0) begin n_fail++; $display("FAIL rst_ops: got %h want 0", core_ops); end
        core_done = 1; core_ret = $urandom();
        @(negedge clk);
        core_done = 0; ok = 1;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || busy) ok = 0;
            @(negedge clk);
        end
        n_chk++; if (ok !== 1) begin n_fail++; $display("FAIL rst_no_rsp: got %b want 1", ok); end
    endtask

    task automatic test_saturate;
        bit got, ops_ok, st, rr; logic [31:0] d, ret; logic [15:0] c; logic e; int sh;
        sel = 1; ret = $urandom();
        run_job(rand_job(), 3, 37, ret, 0, 0, 0, got, d, c, e, sh, ops_ok, st, rr);
        n_chk++; if (c !== 16'd15) begin n_fail++; $display("FAIL sat_cycles: got %0d want 15", c); end
        n_chk++; if ({got, d, e} !== {1'b1, ret, 1'b0}) begin n_fail++; $display("FAIL sat_rsp: got %b %h %b want 1 %h 0", got, d, e, ret); end
    endtask

    task automatic test_random;
        bit got, ops_ok, st, rr, hang; logic [31:0] d, ret; logic [15:0] c; logic e; int sh, rd, dd, cw;
        for (int i = 0; i < 20; i++) begin
            sel = i >= 12;
            cw = sel ? 4 : 16;
            rd = $urandom_range(0, 4);
            dd = sel ? $urandom_range(0, 40) : $urandom_range(0, 8);
            hang = !sel && $urandom_range(0, 4) == 0;
            ret = $urandom();
            run_job(rand_job(), rd, dd, ret, hang, $urandom_range(0, 3), 0, got, d, c, e, sh, ops_ok, st, rr);
            n_chk++;
            if ({got, d, e} !== {1'b1, hang ? 32'd0 : ret, hang}) begin
                n_fail++; $display("FAIL rand_rsp[%0d]: got %b %h %b want 1 %h %b", i, got, d, e, hang ? 32'd0 : ret, hang);
            end
            n_chk++;
            if (ops_ok !== 1 || st !== 1 || sh !== rd + 1) begin
                n_fail++; $display("FAIL rand_start[%0d]: ops %b stable %b start %0d want 1 1 %0d", i, ops_ok, st, sh, rd + 1);
            end
            if (!hang) begin
                n_chk++;
                if (c !== exp_cycles(rd, dd, cw)) begin n_fail++; $display("FAIL rand_cycles[%0d]: got %0d want %0d", i, c, exp_cycles(rd, dd, cw)); end
            end
        end
        sel = 0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_slow_core;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        test_saturate;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
